alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 The block SHALL have a derived localparam SW = log2(WIDTH), the shift-amount width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; the ports are listed below, clock and reset first.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request valid; sampled only in IDLE.
REQ-007 AluOp  in  2  00 add, 01 sub, 10 R-type (decode Func), 11 or.
REQ-008 Func  in  6  R-type function code.
REQ-009 A  in  WIDTH  operand rs.
REQ-010 B  in  WIDTH  operand rt or zero/sign-extended immediate, prepared by the caller.
REQ-011 shamt  in  SW  shift amount for sll.
REQ-012 Result  out  WIDTH  registered result.
REQ-013 Zero  out  1  registered; 1 when Result == 0.
REQ-014 JR  out  1  one-cycle pulse on an accepted jr.
REQ-015 busy  out  1  1 while the multiplier runs.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 illegal  out  1  one-cycle pulse on an unsupported Func.
REQ-018 hi, lo  out  WIDTH each  multiply product registers.

Function
REQ-019 The block SHALL have two states: IDLE and MUL.
REQ-020 In IDLE with start=1, the block SHALL decode AluOp and Func at that edge (edge k).
REQ-021 Single-cycle operations SHALL update Result and Zero at edge k and SHALL pulse done during cycle k..k+1:
- AluOp 00 → A+B
- AluOp 01 → A−B
- AluOp 11 → A|B
- Func 32 → add
- Func 34 → sub
- Func 36 → and
- Func 37 → or
- Func 42 → slt (signed; 1 or 0 zero-extended)
- Func 0 → B << shamt
- Func 16 → mfhi (Result = hi)
- Func 18 → mflo (Result = lo)
REQ-022 Add and sub SHALL wrap modulo 2^WIDTH; no overflow output.
REQ-023 Func 8 (jr) SHALL pulse JR and done at edge k and SHALL leave Result and Zero unchanged.
REQ-024 Any other Func with AluOp 10 SHALL pulse illegal and done, set Result to 0 and Zero to 1, and leave JR at 0.
REQ-025 JR SHALL never be 1 outside an accepted jr.
REQ-026 Func 24 (mult, signed) and Func 25 (multu) SHALL move the block to MUL at edge k, latch the operands, set busy=1, and load the step counter with WIDTH.
REQ-027 The multiplier SHALL be shift-add, one step per clock; for mult it SHALL use operand magnitudes and negate the 2·WIDTH product when the operand signs differ.
REQ-028 The multiplier SHALL write {hi,lo} and return to IDLE at edge k+WIDTH, with busy=0 and done=1 during the following cycle.
REQ-029 Result, Zero, JR and illegal SHALL be unchanged by a multiply.
REQ-030 start SHALL be ignored while busy=1; no queueing and no error pulse.
REQ-031 Operand inputs SHALL be don't-care after edge k.
REQ-032 mfhi or mflo issued on the cycle done rises SHALL return the new product.
REQ-033 done, JR and illegal SHALL each be 1 for exactly one cycle per accepted request.
REQ-034 Back-to-back single-cycle requests SHALL be accepted on consecutive cycles.
REQ-035 The multiplier SHALL be fully sequential: no WIDTH×WIDTH combinational multiplier.

Reset
REQ-036 rst=1 at a rising edge SHALL force state IDLE and set Result, hi, lo, and the counter to 0.
REQ-037 rst=1 at a rising edge SHALL set Zero=1 and JR=0, busy=0, done=0, illegal=0.
REQ-038 Reset SHALL take priority over start.
REQ-039 Reset during MUL SHALL abort the operation, produce no done pulse, and leave hi and lo at 0.
REQ-040 The first start SHALL be accepted on the first edge after rst falls.

Verification (WIDTH=32)
REQ-041 Add and flags scenario:
- AluOp=10, Func=32, A=5, B=7 → Result=12, Zero=0, one done pulse one cycle later.
- Then AluOp=01, A=B=3 → Result=0, Zero=1.
REQ-042 Signed multiply scenario: Func=24, A=0xFFFFFFFB (−5), B=3 → busy high 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse; a following mflo returns 0xFFFFFFF1.
REQ-043 Unsigned multiply with ignored start: Func=25, A=0xFFFFFFFF, B=2 → hi=0x00000001, lo=0xFFFFFFFE; an add start issued mid-multiply changes nothing and produces no extra done.
REQ-044 jr, illegal, slt and sll scenario:
- Func=8 → JR and done pulse once; Result holds its previous value.
- Func=63 → illegal=1, Result=0, JR=0.
- slt with A=0x80000000, B=1 → Result=1.
- sll with B=1, shamt=31 → Result=0x80000000.
REQ-045 Reset mid-multiply: assert rst at cycle 10 of a mult → busy=0, hi=lo=0, no done; a new add accepted on the next edge completes normally.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU controller with single-cycle ops, jr/illegal pulses and sequential shift-add multiplier
module alu_seq_ctrl #(
  parameter int WIDTH = 32,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       AluOp,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SW-1:0]    shamt,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             JR,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SW:0] CNT_INIT = (SW+1)'(WIDTH);
  localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);

  typedef enum logic {IDLE, MUL} state_t;
  typedef enum logic [1:0] {K_ALU, K_JR, K_ILL, K_MUL} kind_t;

  state_t             state;
  kind_t              kind;
  logic [WIDTH-1:0]   alu_res;
  logic [SW:0]        cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic               neg;
  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [2*WIDTH-1:0] prod_final;

  // Decode the request and compute the single-cycle result from the live inputs
  always_comb begin
    alu_res = '0;
    kind    = K_ALU;
    case (AluOp)
      2'b00: alu_res = A + B;
      2'b01: alu_res = A - B;
      2'b11: alu_res = A | B;
      default: begin
        case (Func)
          6'd32: alu_res = A + B;
          6'd34: alu_res = A - B;
          6'd36: alu_res = A & B;
          6'd37: alu_res = A | B;
          6'd42: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
          6'd0:  alu_res = B << shamt;
          6'd16: alu_res = hi;
          6'd18: alu_res = lo;
          6'd8:  kind = K_JR;
          6'd24, 6'd25: kind = K_MUL;
          default: kind = K_ILL;
        endcase
      end
    endcase
  end

  // Operand magnitudes for mult; multu passes operands through untouched
  always_comb begin
    is_signed = (Func == 6'd24);
    a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
    b_mag = (is_signed && B[WIDTH-1]) ? -B : B;
  end

  // One shift-add step: conditionally add the multiplicand into the upper half, then shift right
  always_comb begin
    step_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
    prod_next  = {step_sum, prod[WIDTH-1:1]};
    prod_final = neg ? -prod_next : prod_next;
  end

  // Control FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      Result  <= '0;
      Zero    <= 1'b1;
      JR      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      mcand   <= '0;
      prod    <= '0;
      neg     <= 1'b0;
    end else begin
      done    <= 1'b0;
      JR      <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (kind)
              K_ALU: begin
                Result <= alu_res;
                Zero   <= (alu_res == '0);
                done   <= 1'b1;
              end
              K_JR: begin
                JR   <= 1'b1;
                done <= 1'b1;
              end
              K_ILL: begin
                illegal <= 1'b1;
                Result  <= '0;
                Zero    <= 1'b1;
                done    <= 1'b1;
              end
              default: begin
                state <= MUL;
                busy  <= 1'b1;
                cnt   <= CNT_INIT;
                mcand <= a_mag;
                prod  <= {{WIDTH{1'b0}}, b_mag};
                neg   <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              end
            endcase
          end
        end
        default: begin
          prod <= prod_next;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            hi    <= prod_final[2*WIDTH-1:WIDTH];
            lo    <= prod_final[WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
